// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions: reset vector, widths and the fetch-to-decode payload.
package cpu_defs;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_W     = 32;
    localparam int unsigned IBUF_DEPTH = 3;
    localparam logic [XLEN-1:0] RESET_PC = 32'h1c00_0000;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fs_to_ds_t;

endpackage

// File: rtl/if_ibuf.sv
// Instruction buffer: small synchronous FIFO of {pc, inst} entries with flush.
module if_ibuf
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH = IBUF_DEPTH,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fs_to_ds_t        push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] occupancy,
    output fs_to_ds_t        head
);

    fs_to_ds_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop = pop && (occupancy != '0);
    assign head   = mem[rd_ptr];

    // Flush only rewinds pointers; stale entries are invisible once occupancy is zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited PC generation on a split-handshake SRAM port,
// in-order response tagging, buffering toward decode, and redirect with in-flight cancel.
module if_stage #(
    parameter logic [31:0]  RESET_PC   = cpu_defs::RESET_PC,
    parameter int unsigned  IBUF_DEPTH = cpu_defs::IBUF_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);
    import cpu_defs::*;

    localparam int unsigned CNT_W = $clog2(IBUF_DEPTH + 1);
    localparam int unsigned PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic             reset_d;
    logic [XLEN-1:0]  fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] cancel;
    logic [CNT_W-1:0] occupancy;
    logic [XLEN-1:0]  pcq [IBUF_DEPTH];
    logic [PTR_W-1:0] pcq_wr;
    logic [PTR_W-1:0] pcq_rd;
    logic             accept;
    logic             push;
    logic             pop;
    fs_to_ds_t        push_data;
    fs_to_ds_t        head;
    logic             unused_bits;

    // Credit: never have more requests in flight plus buffered than buffer entries.
    assign inst_sram_req  = !reset_d
                            && ((SUM_W'(outstanding) + SUM_W'(occupancy)) < SUM_W'(IBUF_DEPTH));
    assign inst_sram_addr = {fetch_pc[31:2], 2'b00};
    assign accept         = inst_sram_req && inst_sram_addr_ok;

    assign outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(inst_sram_data_ok);
    assign push            = inst_sram_data_ok && (cancel == '0) && !br_taken;
    assign pop             = fs_to_ds_valid && ds_allowin;
    assign push_data       = '{pc: pcq[pcq_rd], inst: inst_sram_rdata};
    assign unused_bits     = ^br_target[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reset_d     <= 1'b1;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            cancel      <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            for (int unsigned i = 0; i < IBUF_DEPTH; i++) begin
                pcq[i] <= '0;
            end
        end else begin
            reset_d     <= 1'b0;
            outstanding <= outstanding_nxt;
            // A redirect turns every request still in flight after this cycle into a drop.
            if (br_taken) begin
                fetch_pc <= {br_target[31:2], 2'b00};
                cancel   <= outstanding_nxt;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (inst_sram_data_ok && (cancel != '0)) begin
                    cancel <= cancel - CNT_W'(1);
                end
            end
            // PC queue tracks every accepted request, cancelled or not, to stay aligned.
            if (accept) begin
                pcq[pcq_wr] <= inst_sram_addr;
                pcq_wr      <= (pcq_wr == PTR_W'(IBUF_DEPTH - 1)) ? '0 : pcq_wr + 1'b1;
            end
            if (inst_sram_data_ok) begin
                pcq_rd <= (pcq_rd == PTR_W'(IBUF_DEPTH - 1)) ? '0 : pcq_rd + 1'b1;
            end
        end
    end

    if_ibuf #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (br_taken),
        .occupancy (occupancy),
        .head      (head)
    );

    assign fs_to_ds_valid = (occupancy != '0);
    assign fs_pc          = head.pc;
    assign fs_inst        = head.inst;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: behavioural SRAM with grant budget, address and output scoreboards.
module tb_if_stage;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    int compared   = 0;
    int mismatched = 0;

    fs_to_ds_t   exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] resp_q[$];
    int          budget    = 0;
    int          acc_cnt   = 0;
    bit          hold_data = 1'b0;
    bit          chk_en    = 1'b0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_pc             (fs_pc),
        .fs_inst           (fs_inst)
    );

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return a ^ 32'h5a5a_a5a5;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(logic [31:0] pc, bit delivered);
        exp_addr_q.push_back(pc);
        if (delivered) exp_q.push_back('{pc: pc, inst: inst_of(pc)});
    endtask

    // Returns in "cycle 0": reset just released, first request due next cycle.
    task automatic do_reset();
        reset      = 1'b1;
        br_taken   = 1'b0;
        br_target  = '0;
        ds_allowin = 1'b0;
        budget     = 0;
        hold_data  = 1'b0;
        chk_en     = 1'b0;
        repeat (2) next_cycle();
        exp_q.delete();
        exp_addr_q.delete();
        resp_q.delete();
        acc_cnt = 0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic drain(string name, int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && n < max_cycles) begin
            next_cycle();
            n++;
        end
        compared++;
        if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: %0d outputs and %0d addresses still pending after %0d cycles, expected 0",
                     name, exp_q.size(), exp_addr_q.size(), n);
            exp_q.delete();
            exp_addr_q.delete();
        end
    endtask

    // SRAM: ready while budget lasts, data one cycle after accept, in order.
    initial begin
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = '0;
        forever begin
            @(posedge clk);
            #2;
            inst_sram_addr_ok = !reset && (budget > 0);
            if (!reset && !hold_data && resp_q.size() > 0) begin
                inst_sram_data_ok = 1'b1;
                inst_sram_rdata   = inst_of(resp_q.pop_front());
            end else begin
                inst_sram_data_ok = 1'b0;
                inst_sram_rdata   = '0;
            end
            @(negedge clk);
            if (reset) begin
                resp_q.delete();
            end else if (inst_sram_req && inst_sram_addr_ok) begin
                resp_q.push_back(inst_sram_addr);
                budget--;
                acc_cnt++;
                if (chk_en) begin
                    if (exp_addr_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL addr_unexpected: got %08h expected no request", inst_sram_addr);
                    end else begin
                        check("addr", inst_sram_addr, exp_addr_q.pop_front());
                    end
                end
            end
        end
    end

    // Output monitor: compares every decode handshake against the expected queue.
    initial begin
        fs_to_ds_t e;
        forever begin
            @(negedge clk);
            if (!reset && chk_en && fs_to_ds_valid && ds_allowin) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL out_unexpected: got pc %08h expected no output", fs_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", fs_pc, e.pc);
                    check("out_inst", fs_inst, e.inst);
                end
            end
            if (!reset && dut.push && (int'(dut.occupancy) >= IBUF_DEPTH) && !br_taken) begin
                mismatched++;
                $display("FAIL ibuf_overflow: push with occupancy %0d, expected below %0d",
                         dut.occupancy, IBUF_DEPTH);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: streaming fetch from reset, one instruction per cycle
        do_reset();
        check("t1_req_c0", 32'(inst_sram_req), 32'd0);
        check("t1_valid_c0", 32'(fs_to_ds_valid), 32'd0);
        check("t1_pc_c0", fs_pc, 32'h0);
        check("t1_inst_c0", fs_inst, 32'h0);
        ds_allowin = 1'b1;
        budget     = 8;
        chk_en     = 1'b1;
        for (int i = 0; i < 8; i++) expect_fetch(32'h1c00_0000 + 32'(4 * i), 1'b1);
        next_cycle();
        check("t1_req_c1", 32'(inst_sram_req), 32'd1);
        check("t1_addr_c1", inst_sram_addr, 32'h1c00_0000);
        check("t1_valid_c1", 32'(fs_to_ds_valid), 32'd0);
        next_cycle();
        check("t1_valid_c2", 32'(fs_to_ds_valid), 32'd0);
        next_cycle();
        check("t1_valid_c3", 32'(fs_to_ds_valid), 32'd1);
        check("t1_pc_c3", fs_pc, 32'h1c00_0000);
        drain("t1", 8);

        // 2: decode stalled, credit caps requests at three
        do_reset();
        budget = 8;
        chk_en = 1'b1;
        for (int i = 0; i < 8; i++) expect_fetch(32'h1c00_0000 + 32'(4 * i), 1'b1);
        repeat (10) next_cycle();
        check("t2_accepted", 32'(acc_cnt), 32'd3);
        check("t2_req", 32'(inst_sram_req), 32'd0);
        check("t2_valid", 32'(fs_to_ds_valid), 32'd1);
        check("t2_pc", fs_pc, 32'h1c00_0000);
        check("t2_inst", fs_inst, inst_of(32'h1c00_0000));
        ds_allowin = 1'b1;
        drain("t2", 30);

        // 3: addr_ok withheld, request held stable
        do_reset();
        ds_allowin = 1'b1;
        chk_en     = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            check("t3_req", 32'(inst_sram_req), 32'd1);
            check("t3_addr", inst_sram_addr, 32'h1c00_0000);
            check("t3_valid", 32'(fs_to_ds_valid), 32'd0);
        end
        next_cycle();
        budget = 2;
        expect_fetch(32'h1c00_0000, 1'b1);
        expect_fetch(32'h1c00_0004, 1'b1);
        drain("t3", 10);

        // 4: redirect with one buffered and two outstanding
        do_reset();
        budget = 1;
        chk_en = 1'b1;
        expect_fetch(32'h1c00_0000, 1'b0);
        next_cycle();
        next_cycle();
        next_cycle();
        hold_data = 1'b1;
        budget    = 2;
        expect_fetch(32'h1c00_0004, 1'b0);
        expect_fetch(32'h1c00_0008, 1'b0);
        next_cycle();
        next_cycle();
        check("t4_req_full", 32'(inst_sram_req), 32'd0);
        check("t4_valid_pre", 32'(fs_to_ds_valid), 32'd1);
        check("t4_pc_pre", fs_pc, 32'h1c00_0000);
        br_taken  = 1'b1;
        br_target = 32'h1c00_0100;
        next_cycle();
        br_taken   = 1'b0;
        hold_data  = 1'b0;
        budget     = 2;
        ds_allowin = 1'b1;
        check("t4_valid_flushed", 32'(fs_to_ds_valid), 32'd0);
        check("t4_req_post", 32'(inst_sram_req), 32'd1);
        check("t4_addr_post", inst_sram_addr, 32'h1c00_0100);
        expect_fetch(32'h1c00_0100, 1'b1);
        expect_fetch(32'h1c00_0104, 1'b1);
        drain("t4", 15);

        // 5: redirect coinciding with addr_ok and data_ok
        do_reset();
        ds_allowin = 1'b1;
        budget     = 2;
        chk_en     = 1'b1;
        expect_fetch(32'h1c00_0000, 1'b0);
        expect_fetch(32'h1c00_0004, 1'b0);
        next_cycle();
        next_cycle();
        br_taken  = 1'b1;
        br_target = 32'h1c00_0100;
        next_cycle();
        br_taken = 1'b0;
        budget   = 2;
        check("t5_valid_post", 32'(fs_to_ds_valid), 32'd0);
        check("t5_addr_post", inst_sram_addr, 32'h1c00_0100);
        expect_fetch(32'h1c00_0100, 1'b1);
        expect_fetch(32'h1c00_0104, 1'b1);
        drain("t5", 15);

        // 6: asynchronous reset mid-stream, restart at reset vector
        do_reset();
        ds_allowin = 1'b1;
        budget     = 100;
        repeat (6) next_cycle();
        check("t6_valid_running", 32'(fs_to_ds_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_req_rst", 32'(inst_sram_req), 32'd0);
        check("t6_valid_rst", 32'(fs_to_ds_valid), 32'd0);
        check("t6_pc_rst", fs_pc, 32'h0);
        check("t6_inst_rst", fs_inst, 32'h0);
        do_reset();
        ds_allowin = 1'b1;
        budget     = 3;
        chk_en     = 1'b1;
        for (int i = 0; i < 3; i++) expect_fetch(32'h1c00_0000 + 32'(4 * i), 1'b1);
        next_cycle();
        check("t6_addr_restart", inst_sram_addr, 32'h1c00_0000);
        drain("t6", 10);

        // 7: unaligned redirect target near the top of memory, PC wraps to zero
        do_reset();
        ds_allowin = 1'b1;
        chk_en     = 1'b1;
        next_cycle();
        br_taken  = 1'b1;
        br_target = 32'hffff_fffe;
        next_cycle();
        br_taken = 1'b0;
        check("t7_addr_aligned", inst_sram_addr, 32'hffff_fffc);
        budget = 2;
        expect_fetch(32'hffff_fffc, 1'b1);
        expect_fetch(32'h0000_0000, 1'b1);
        drain("t7", 10);

        repeat (3) next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
